// File: rtl/timer_bank_pkg.sv
// Shared encodings for the timer_bank register bus and channel control word.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_bank_pkg;

    // Register bus selectors. Write slot 3 is FLAG_CLR and read slot 3 is CAPTURE.
    localparam logic [1:0] SEL_CTRL     = 2'd0;
    localparam logic [1:0] SEL_RELOAD   = 2'd1;
    localparam logic [1:0] SEL_COUNT    = 2'd2;
    localparam logic [1:0] SEL_FLAG_CLR = 2'd3;
    localparam logic [1:0] SEL_CAPTURE  = 2'd3;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'd0,
        MODE_RELOAD  = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    // CTRL word bit positions
    localparam int CTRL_RUN      = 0;
    localparam int CTRL_EXT      = 1;
    localparam int CTRL_GATE_EN  = 2;
    localparam int CTRL_MODE     = 3;   // 2 bits
    localparam int CTRL_IE       = 5;
    localparam int CTRL_PRESCALE = 6;   // PRESCALE_W bits

    // The raw mode field has a fourth code (3) that behaves as free-run.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_RELOAD;
            2'd2:    return MODE_ONESHOT;
            default: return MODE_FREE;
        endcase
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer/counter channel: synchronisers, prescaler, counter, reload/one-shot, sticky flag, optional capture.
// Latency: register writes land at the write edge; ext pin edges reach COUNT two edges after sampling.
// Backpressure: none; writes always accepted.
// Ports: clk/reset; per-register write strobes + wr_data_i; async pins cnt_in_i/gate_i/cap_in_i;
//        register views ctrl_o/reload_o/count_o/capture_o; ovf_o flag and ie_o enable.
// Optional capture register compiled in with TIMER_BANK_CAPTURE_EN.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int PRESCALE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_ctrl_i,
    input  logic             wr_reload_i,
    input  logic             wr_count_i,
    input  logic             wr_flag_clr_i,
    input  logic [CNT_W-1:0] wr_data_i,
    input  logic             cnt_in_i,
    input  logic             gate_i,
    input  logic             cap_in_i,
    output logic [CNT_W-1:0] ctrl_o,
    output logic [CNT_W-1:0] reload_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] capture_o,
    output logic             ovf_o,
    output logic             ie_o
);

    logic                  run_q, run_d;
    logic                  ext_q;
    logic                  gate_en_q;
    logic [1:0]            mode_q;
    logic                  ie_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] psc_q, psc_d;
    logic [CNT_W-1:0]      reload_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  flag_q, flag_d;
    logic [2:0]            cnt_sync_q;   // [1] is the synchronised level, [2] its delayed copy
    logic [1:0]            gate_sync_q;

    logic enable, cnt_fall, tick, ovf;
    mode_e mode;

    always_comb begin
        mode     = decode_mode(mode_q);
        enable   = run_q && (!gate_en_q || gate_sync_q[1]);
        cnt_fall = cnt_sync_q[2] && !cnt_sync_q[1];
        tick     = enable && (ext_q ? cnt_fall : (psc_q == prescale_q));
        // A COUNT write replaces the tick entirely, so it also suppresses overflow.
        ovf      = tick && !wr_count_i && (&count_q);

        psc_d = psc_q;
        if (wr_ctrl_i) begin
            psc_d = '0;
        end else if (enable && !ext_q) begin
            psc_d = (psc_q == prescale_q) ? '0 : psc_q + PRESCALE_W'(1);
        end

        count_d = count_q;
        if (wr_count_i) begin
            count_d = wr_data_i;
        end else if (ovf) begin
            count_d = (mode == MODE_FREE) ? '0 : reload_q;
        end else if (tick) begin
            count_d = count_q + CNT_W'(1);
        end

        // The written run bit wins over a one-shot auto-stop on the same edge.
        run_d = run_q;
        if (wr_ctrl_i) begin
            run_d = wr_data_i[CTRL_RUN];
        end else if (ovf && mode == MODE_ONESHOT) begin
            run_d = 1'b0;
        end

        // Overflow wins over a same-edge clear.
        flag_d = flag_q;
        if (ovf) begin
            flag_d = 1'b1;
        end else if (wr_flag_clr_i && wr_data_i[0]) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q       <= 1'b0;
            ext_q       <= 1'b0;
            gate_en_q   <= 1'b0;
            mode_q      <= 2'd0;
            ie_q        <= 1'b0;
            prescale_q  <= '0;
            psc_q       <= '0;
            reload_q    <= '0;
            count_q     <= '0;
            flag_q      <= 1'b0;
            cnt_sync_q  <= '0;
            gate_sync_q <= '0;
        end else begin
            run_q       <= run_d;
            psc_q       <= psc_d;
            count_q     <= count_d;
            flag_q      <= flag_d;
            cnt_sync_q  <= {cnt_sync_q[1:0], cnt_in_i};
            gate_sync_q <= {gate_sync_q[0], gate_i};
            if (wr_ctrl_i) begin
                ext_q      <= wr_data_i[CTRL_EXT];
                gate_en_q  <= wr_data_i[CTRL_GATE_EN];
                mode_q     <= wr_data_i[CTRL_MODE +: 2];
                ie_q       <= wr_data_i[CTRL_IE];
                prescale_q <= wr_data_i[CTRL_PRESCALE +: PRESCALE_W];
            end
            if (wr_reload_i) begin
                reload_q <= wr_data_i;
            end
        end
    end

`ifdef TIMER_BANK_CAPTURE_EN
    logic [2:0]       cap_sync_q;
    logic [CNT_W-1:0] capture_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_sync_q <= '0;
            capture_q  <= '0;
        end else begin
            cap_sync_q <= {cap_sync_q[1:0], cap_in_i};
            // Latch the pre-increment COUNT on a synchronised rising edge.
            if (cap_sync_q[1] && !cap_sync_q[2]) begin
                capture_q <= count_q;
            end
        end
    end

    assign capture_o = capture_q;
`else
    logic unused_cap_in;
    assign unused_cap_in = cap_in_i;
    assign capture_o     = '0;
`endif

    always_comb begin
        ctrl_o                              = '0;
        ctrl_o[CTRL_RUN]                    = run_q;
        ctrl_o[CTRL_EXT]                    = ext_q;
        ctrl_o[CTRL_GATE_EN]                = gate_en_q;
        ctrl_o[CTRL_MODE +: 2]              = mode_q;
        ctrl_o[CTRL_IE]                     = ie_q;
        ctrl_o[CTRL_PRESCALE +: PRESCALE_W] = prescale_q;
    end

    assign reload_o = reload_q;
    assign count_o  = count_q;
    assign ovf_o    = flag_q;
    assign ie_o     = ie_q;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel timer/counter bank: write demux, registered read mux and irq OR around NUM_CH channels.
// Latency: writes take effect at the write edge; rd_data is registered, one cycle after rd_ch/rd_sel.
// Backpressure: none; the register bus is always ready.
// Ports: clk, reset (sync, active-high); write bus wr_en/wr_ch/wr_sel/wr_data; read bus rd_ch/rd_sel/rd_data;
//        async pins cnt_in/gate/cap_in (one per channel); sticky ovf_flag per channel; irq.
// Optional capture feature compiled in with TIMER_BANK_CAPTURE_EN (otherwise rd_sel=3 reads 0).
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter  int NUM_CH     = 2,
    parameter  int CNT_W      = 16,
    parameter  int PRESCALE_W = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [1:0]        wr_sel,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [1:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    input  logic [NUM_CH-1:0] cnt_in,
    input  logic [NUM_CH-1:0] gate,
    input  logic [NUM_CH-1:0] cap_in,
    output logic [NUM_CH-1:0] ovf_flag,
    output logic              irq
);

    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] ie_v;
    logic [CNT_W-1:0]  ctrl_v    [NUM_CH];
    logic [CNT_W-1:0]  reload_v  [NUM_CH];
    logic [CNT_W-1:0]  count_v   [NUM_CH];
    logic [CNT_W-1:0]  capture_v [NUM_CH];
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;

    // Channel numbers beyond NUM_CH (non-power-of-two banks) decode to nothing.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = wr_en && (wr_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(
            .CNT_W      (CNT_W),
            .PRESCALE_W (PRESCALE_W)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .wr_ctrl_i     (wr_hit[g] && (wr_sel == SEL_CTRL)),
            .wr_reload_i   (wr_hit[g] && (wr_sel == SEL_RELOAD)),
            .wr_count_i    (wr_hit[g] && (wr_sel == SEL_COUNT)),
            .wr_flag_clr_i (wr_hit[g] && (wr_sel == SEL_FLAG_CLR)),
            .wr_data_i     (wr_data),
            .cnt_in_i      (cnt_in[g]),
            .gate_i        (gate[g]),
            .cap_in_i      (cap_in[g]),
            .ctrl_o        (ctrl_v[g]),
            .reload_o      (reload_v[g]),
            .count_o       (count_v[g]),
            .capture_o     (capture_v[g]),
            .ovf_o         (ovf_flag[g]),
            .ie_o          (ie_v[g])
        );
    end

    // Read samples pre-edge register state, so a same-edge write is not visible.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                case (rd_sel)
                    SEL_CTRL:   rd_data_d = ctrl_v[i];
                    SEL_RELOAD: rd_data_d = reload_v[i];
                    SEL_COUNT:  rd_data_d = count_v[i];
                    default:    rd_data_d = capture_v[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign irq     = |(ovf_flag & ie_v);

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank (2 channels, 16-bit counters, 4-bit prescale).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Capture checks follow TIMER_BANK_CAPTURE_EN.
module tb_timer_bank;
    import timer_bank_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [0:0]  wr_ch;
    logic [1:0]  wr_sel;
    logic [15:0] wr_data;
    logic [0:0]  rd_ch;
    logic [1:0]  rd_sel;
    logic [15:0] rd_data;
    logic [1:0]  cnt_in;
    logic [1:0]  gate;
    logic [1:0]  cap_in;
    logic [1:0]  ovf_flag;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    timer_bank #(
        .NUM_CH     (2),
        .CNT_W      (16),
        .PRESCALE_W (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .rd_ch    (rd_ch),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .cnt_in   (cnt_in),
        .gate     (gate),
        .cap_in   (cap_in),
        .ovf_flag (ovf_flag),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ctrl_w(input bit run, input bit ext, input bit gen,
                                           input logic [1:0] mode, input bit ie, input logic [3:0] psc);
        return {6'd0, psc, ie, mode, gen, ext, run};
    endfunction

    // One write lands at the next edge; returns just after that edge.
    task automatic wr(input int ch, input logic [1:0] sel, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_ch   = 1'(ch);
        wr_sel  = sel;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input int ch, input logic [1:0] sel, output logic [15:0] v);
        rd_ch  = 1'(ch);
        rd_sel = sel;
        cyc();
        v = rd_data;
    endtask

    task automatic pulse(input int ch);
        cnt_in[ch] = 1'b0;
        repeat (3) cyc();
        cnt_in[ch] = 1'b1;
        repeat (3) cyc();
    endtask

    initial begin
        logic [15:0] v;
        reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0;
        rd_ch = '0; rd_sel = '0; cnt_in = 2'b11; gate = 2'b00; cap_in = 2'b00;

        // Reset state
        repeat (3) cyc();
        check("rst_rd_data", rd_data, 0);
        check("rst_flags", ovf_flag, 0);
        check("rst_irq", irq, 0);
        reset = 1'b0;
        rd(0, SEL_CTRL, v);
        check("rst_ctrl0", v, 0);

        // Timer free-run, prescale 2: one tick every 3 cycles
        wr(0, SEL_COUNT, 16'hFFFE);
        rd_ch = 1'b0; rd_sel = SEL_COUNT;
        wr(0, SEL_CTRL, ctrl_w(1, 0, 0, 2'd0, 1, 4'd2));   // edge N
        repeat (3) cyc();
        check("fr_hold", rd_data, 16'hFFFE);              // COUNT after N+2
        cyc();
        check("fr_step", rd_data, 16'hFFFF);              // COUNT after N+3
        cyc();
        check("fr_noflag", ovf_flag[0], 0);
        cyc();
        check("fr_flag", ovf_flag[0], 1);
        check("fr_irq", irq, 1);
        cyc();
        check("fr_wrap", rd_data, 16'h0000);
        wr(0, SEL_CTRL, 16'h0000);
        wr(0, SEL_FLAG_CLR, 16'h0001);
        check("fr_clr", ovf_flag[0], 0);
        check("fr_irq_off", irq, 0);

        // Auto-reload on channel 1
        wr(1, SEL_RELOAD, 16'hFF00);
        wr(1, SEL_COUNT, 16'hFFFF);
        rd_ch = 1'b1; rd_sel = SEL_COUNT;
        wr(1, SEL_CTRL, ctrl_w(1, 0, 0, 2'd1, 0, 4'd0));  // edge N
        cyc();
        check("ar_flag", ovf_flag[1], 1);
        cyc();
        check("ar_reload", rd_data, 16'hFF00);
        check("ar_irq_masked", irq, 0);
        wr(1, SEL_CTRL, 16'h0000);
        wr(1, SEL_FLAG_CLR, 16'h0000);
        check("ar_clr_bit0_zero", ovf_flag[1], 1);
        wr(1, SEL_FLAG_CLR, 16'h0001);
        check("ar_clr", ovf_flag[1], 0);
        wr(1, SEL_COUNT, 16'hFFFF);
        wr(1, SEL_CTRL, ctrl_w(1, 0, 0, 2'd1, 0, 4'd0));  // edge M
        wr(1, SEL_FLAG_CLR, 16'h0001);                    // M+1, overflow too
        check("ar_ovf_beats_clr", ovf_flag[1], 1);
        wr(1, SEL_CTRL, 16'h0000);
        wr(1, SEL_FLAG_CLR, 16'h0001);

        // One-shot external counter on channel 0
        wr(0, SEL_RELOAD, 16'h0100);
        wr(0, SEL_COUNT, 16'hFFFD);
        wr(0, SEL_CTRL, ctrl_w(1, 1, 0, 2'd2, 0, 4'd0));
        repeat (3) pulse(0);
        rd(0, SEL_COUNT, v);
        check("os_reload", v, 16'h0100);
        rd(0, SEL_CTRL, v);
        check("os_run_clr", v, ctrl_w(0, 1, 0, 2'd2, 0, 4'd0));
        check("os_flag", ovf_flag[0], 1);
        pulse(0);
        rd(0, SEL_COUNT, v);
        check("os_stopped", v, 16'h0100);
        wr(0, SEL_FLAG_CLR, 16'h0001);

        // Gating on channel 1
        wr(1, SEL_COUNT, 16'h0000);
        wr(1, SEL_CTRL, ctrl_w(1, 0, 1, 2'd0, 0, 4'd0));
        repeat (20) cyc();
        rd(1, SEL_COUNT, v);
        check("gt_frozen", v, 16'h0000);
        gate[1] = 1'b1;                                   // sampled at edge k
        cyc();
        cyc();
        check("gt_k1", rd_data, 16'h0000);
        cyc();
        check("gt_k2", rd_data, 16'h0000);
        cyc();
        check("gt_k3", rd_data, 16'h0001);
        cyc();
        check("gt_k4", rd_data, 16'h0002);
        gate[1] = 1'b0;
        wr(1, SEL_CTRL, 16'h0000);

        // COUNT write beats a tick
        wr(0, SEL_COUNT, 16'h0000);
        rd_ch = 1'b0; rd_sel = SEL_COUNT;
        wr(0, SEL_CTRL, ctrl_w(1, 0, 0, 2'd0, 0, 4'd0));
        cyc();
        cyc();
        wr(0, SEL_COUNT, 16'h1234);                       // edge W
        cyc();
        check("col_wr", rd_data, 16'h1234);
        cyc();
        check("col_next", rd_data, 16'h1235);
        wr(0, SEL_CTRL, 16'h0000);
        wr(0, SEL_COUNT, 16'hFFFF);
        wr(0, SEL_CTRL, ctrl_w(1, 0, 0, 2'd0, 0, 4'd0));  // edge M
        wr(0, SEL_COUNT, 16'h0005);                       // M+1 would overflow
        wr(0, SEL_CTRL, 16'h0000);                        // M+2 still ticks
        check("col_noflag", ovf_flag[0], 0);
        rd(0, SEL_COUNT, v);
        check("col_val", v, 16'h0006);

        // Independent channels, prescale 1 vs 3, 24 enabled cycles
        wr(0, SEL_COUNT, 16'h0000);
        wr(1, SEL_COUNT, 16'h0000);
        wr(0, SEL_CTRL, ctrl_w(1, 0, 1, 2'd0, 0, 4'd1));
        wr(1, SEL_CTRL, ctrl_w(1, 0, 1, 2'd0, 0, 4'd3));
        gate = 2'b11;
        repeat (24) cyc();
        gate = 2'b00;
        repeat (4) cyc();
        rd(0, SEL_COUNT, v);
        check("ind_ch0", v, 16'd12);
        rd(1, SEL_COUNT, v);
        check("ind_ch1", v, 16'd6);
        wr(0, SEL_CTRL, 16'h0000);
        wr(1, SEL_CTRL, 16'h0000);

        // Capture
        wr(0, SEL_COUNT, 16'd100);
        wr(0, SEL_CTRL, ctrl_w(1, 0, 0, 2'd0, 0, 4'd0));
        cap_in[0] = 1'b1;
        repeat (4) cyc();
        wr(0, SEL_CTRL, 16'h0000);
        cap_in[0] = 1'b0;
        rd(0, SEL_CAPTURE, v);
`ifdef TIMER_BANK_CAPTURE_EN
        check("cap_val", v, 16'd102);
`else
        check("cap_off", v, 16'd0);
`endif

        // Reset mid-count discards everything
        wr(1, SEL_RELOAD, 16'hFF00);
        wr(1, SEL_COUNT, 16'hFFFF);
        wr(1, SEL_CTRL, ctrl_w(1, 0, 0, 2'd1, 1, 4'd0));
        cyc();
        check("pre_rst_irq", irq, 1);
        reset = 1'b1;
        cyc();
        cyc();
        check("mid_rst_flags", ovf_flag, 0);
        check("mid_rst_irq", irq, 0);
        check("mid_rst_rd", rd_data, 0);
        reset = 1'b0;
        rd(1, SEL_COUNT, v);
        check("mid_rst_count", v, 0);
        rd(1, SEL_CTRL, v);
        check("mid_rst_ctrl", v, 0);
        rd(1, SEL_RELOAD, v);
        check("mid_rst_reload", v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
